// File: rtl/clk_en_nco.sv
// rtl/clk_en_nco.sv - multi-channel fractional clock-enable NCO (optional phase port: CLK_EN_NCO_PHASE_OUT_EN)
module clk_en_nco #(
  parameter int               IN_FREQ  = 50_000_000,
  parameter int               NUM_CH   = 4,
  parameter int               ACC_W    = 24,
  parameter logic [ACC_W-1:0] INIT_INC = '0
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          run,
  input  logic                                          sync,
  input  logic                                          wr_en,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_ch,
  input  logic [ACC_W-1:0]                              wr_inc,
`ifdef CLK_EN_NCO_PHASE_OUT_EN
  output logic [NUM_CH*8-1:0]                           phase,
`endif
  output logic [NUM_CH-1:0]                             clk_en
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Elaboration-time guard on the supported parameter ranges.
  if (NUM_CH < 1 || NUM_CH > 16 || ACC_W < 8 || ACC_W > 32 || IN_FREQ < 1) begin : g_param_check
    $error("clk_en_nco: parameter out of supported range");
  end

  logic [ACC_W-1:0] acc [NUM_CH];
  logic [ACC_W-1:0] inc [NUM_CH];
  logic [ACC_W:0]   sum [NUM_CH];

  // One extra bit on the adder exposes the wrap as the carry that becomes the pulse.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sum[ch] = {1'b0, acc[ch]} + {1'b0, inc[ch]};
    end
  end

  // Accumulators and pulse outputs; sync clears everything and outranks run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        acc[ch] <= '0;
      end
      clk_en <= '0;
    end else if (sync) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        acc[ch] <= '0;
      end
      clk_en <= '0;
    end else if (run) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        acc[ch]    <= sum[ch][ACC_W-1:0];
        clk_en[ch] <= sum[ch][ACC_W];
      end
    end else begin
      clk_en <= '0;
    end
  end

  // Increment registers; a write lands after the accumulator has used the old value,
  // and an index beyond the last channel matches nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        inc[ch] <= INIT_INC;
      end
    end else if (wr_en) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (wr_ch == CH_W'(ch)) begin
          inc[ch] <= wr_inc;
        end
      end
    end
  end

`ifdef CLK_EN_NCO_PHASE_OUT_EN
  // Coarse phase is the top byte of each accumulator, so it resets and syncs with it.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_phase
    assign phase[8*g +: 8] = acc[g][ACC_W-1 -: 8];
  end
`endif

endmodule
